fetch_decode: RTL and testbench

Instruction fetch and field-decode unit that feeds the multi-cycle controller. It owns the program counter and reads 32-bit instruction words from the instruction RAM. It splits each word into opcode, shift_op, register and immediate fields, and holds them stable with a valid/accept handshake until the controller signals it is waiting for the next instruction. It also handles PC redirects from the controller (load_pc, clear_pc) and stops fetching after an accepted HLT.

---
 rtl/fetch_decode_if.sv | 40 ++++
 rtl/fetch_decode.sv | 100 ++++++++++
 tb/tb_fetch_decode.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_if.sv
// Fetch/decode bundle: instruction-RAM read port plus the controller-facing decoded fields.
// master = fetch_decode, slave = instruction RAM / controller side.
interface fetch_decode_if #(
   parameter int ADDR_W = 11
);
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [31:0]       ram_rd_data;

   logic              waiting;
   logic              load_pc;
   logic [ADDR_W-1:0] pc_in;
   logic              clear_pc;

   logic              instr_valid;
   logic [6:0]        opcode;
   logic [1:0]        shift_op;
   logic [3:0]        rd;
   logic [3:0]        rn;
   logic [3:0]        rs;
   logic [3:0]        rm;
   logic [11:0]       imm12;
   logic [31:0]       br_off;
   logic [ADDR_W-1:0] pc_out;
   logic              halted;

   modport master (
      output ram_rd_en, ram_rd_addr,
      input  ram_rd_data,
      input  waiting, load_pc, pc_in, clear_pc,
      output instr_valid, opcode, shift_op, rd, rn, rs, rm, imm12, br_off, pc_out, halted
   );

   modport slave (
      input  ram_rd_en, ram_rd_addr,
      output ram_rd_data,
      output waiting, load_pc, pc_in, clear_pc,
      input  instr_valid, opcode, shift_op, rd, rn, rs, rm, imm12, br_off, pc_out, halted
   );
endinterface

// File: rtl/fetch_decode.sv
// PC owner and instruction field splitter; FETCH->WAIT->HOLD gives valid 2 cycles after the read.
// Fields are held in HOLD until the controller is waiting; redirects flush any in-flight word.
module fetch_decode #(
   parameter int                ADDR_W   = 11,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   fetch_decode_if.master  bus
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   localparam logic [6:0]        OP_HLT = 7'b0000001;
   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;

   logic              redirect;
   logic              accept;
   logic [ADDR_W-1:0] redirect_pc;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      pc_out_d = pc_out_q;

      redirect    = (bus.clear_pc || bus.load_pc) && (state_q != S_HALT);
      redirect_pc = bus.clear_pc ? RESET_PC : bus.pc_in;
      accept      = (state_q == S_HOLD) && bus.waiting;

      case (state_q)
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            ir_d     = bus.ram_rd_data;
            pc_out_d = pc_q;
            state_d  = S_HOLD;
         end
         S_HOLD: begin
            if (accept) begin
               if (ir_q[31:25] == OP_HLT) begin
                  state_d = S_HALT;
               end else begin
                  pc_d    = pc_q + PC_ONE;
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_HALT;
      endcase

      // Redirect wins over everything: a word still in flight in WAIT is not latched,
      // and an accept in the same cycle consumes the held word without HLT detection.
      if (redirect) begin
         pc_d     = redirect_pc;
         state_d  = S_FETCH;
         ir_d     = ir_q;
         pc_out_d = pc_out_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         pc_out_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         pc_out_q <= pc_out_d;
      end
   end

   // Reset parks the FSM in FETCH, so the strobe is gated to stay quiet while rst_n is low.
   assign bus.ram_rd_en   = rst_n && (state_q == S_FETCH);
   assign bus.ram_rd_addr = pc_q;

   assign bus.instr_valid = (state_q == S_HOLD);
   assign bus.halted      = (state_q == S_HALT);
   assign bus.pc_out      = pc_out_q;

   assign bus.opcode   = ir_q[31:25];
   assign bus.shift_op = ir_q[24:23];
   assign bus.rd       = ir_q[22:19];
   assign bus.rn       = ir_q[18:15];
   assign bus.rs       = ir_q[11:8];
   assign bus.rm       = ir_q[3:0];
   assign bus.imm12    = ir_q[11:0];
   assign bus.br_off   = {{7{ir_q[24]}}, ir_q[24:0]};

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: synchronous-read RAM model, cycle-by-cycle field and handshake checks.
module tb_fetch_decode;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [31:0] mem [0:2047];

   fetch_decode_if #(.ADDR_W(11)) bus ();

   fetch_decode #(.ADDR_W(11), .RESET_PC(11'd0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      mem[0]      = 32'h2200_0000;   // ADD
      mem[1]      = 32'h2400_0000;   // SUB
      mem[2]      = 32'h0180_0001;   // NOP with bit 24 set
      mem[3]      = 32'h0200_0000;   // HLT
      mem[11'h100] = 32'h6CC9_8A35;
      mem[11'h101] = 32'h2200_0000;
      mem[11'h7FF] = 32'h2400_0000;

      rst_n             = 1'b0;
      bus.waiting       = 1'b0;
      bus.load_pc       = 1'b0;
      bus.clear_pc      = 1'b0;
      bus.pc_in         = '0;
      bus.ram_rd_data   = '0;

      tick();
      tick();
      chk("rst_rd_en",  32'(bus.ram_rd_en),   32'd0);
      chk("rst_valid",  32'(bus.instr_valid), 32'd0);
      chk("rst_halted", 32'(bus.halted),      32'd0);
      chk("rst_opcode", 32'(bus.opcode),      32'd0);
      chk("rst_pc_out", 32'(bus.pc_out),      32'd0);
      chk("rst_br_off", bus.br_off,           32'd0);

      // straight-line: cycle 0 is the first FETCH
      bus.waiting = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("c0_rd_en",  32'(bus.ram_rd_en),   32'd1);
      chk("c0_addr",   32'(bus.ram_rd_addr), 32'd0);
      chk("c0_valid",  32'(bus.instr_valid), 32'd0);
      tick();
      chk("c1_valid",  32'(bus.instr_valid), 32'd0);
      chk("c1_rd_en",  32'(bus.ram_rd_en),   32'd0);
      tick();
      chk("c2_valid",  32'(bus.instr_valid), 32'd1);
      chk("c2_opcode", 32'(bus.opcode),      32'h11);
      chk("c2_pc_out", 32'(bus.pc_out),      32'd0);
      tick();
      chk("c3_valid",  32'(bus.instr_valid), 32'd0);
      chk("c3_addr",   32'(bus.ram_rd_addr), 32'd1);
      tick();
      tick();
      chk("c5_valid",  32'(bus.instr_valid), 32'd1);
      chk("c5_opcode", 32'(bus.opcode),      32'h12);
      chk("c5_pc_out", 32'(bus.pc_out),      32'd1);
      tick();
      tick();
      tick();
      chk("c8_valid",  32'(bus.instr_valid), 32'd1);
      chk("c8_opcode", 32'(bus.opcode),      32'h00);
      chk("c8_pc_out", 32'(bus.pc_out),      32'd2);
      chk("c8_shift",  32'(bus.shift_op),    32'd3);
      chk("c8_rm",     32'(bus.rm),          32'd1);
      chk("c8_br_off", bus.br_off,           32'hFF80_0001);
      tick();
      chk("c9_addr",   32'(bus.ram_rd_addr), 32'd3);

      // redirect in a FETCH cycle: the read of word 3 is dropped
      bus.load_pc = 1'b1;
      bus.pc_in   = 11'h100;
      bus.waiting = 1'b0;
      tick();
      bus.load_pc = 1'b0;
      chk("rf_rd_en",  32'(bus.ram_rd_en),   32'd1);
      chk("rf_addr",   32'(bus.ram_rd_addr), 32'h100);
      chk("rf_valid",  32'(bus.instr_valid), 32'd0);
      tick();
      tick();
      chk("fd_valid",  32'(bus.instr_valid), 32'd1);
      chk("fd_pc_out", 32'(bus.pc_out),      32'h100);
      chk("fd_opcode", 32'(bus.opcode),      32'h36);
      chk("fd_shift",  32'(bus.shift_op),    32'h1);
      chk("fd_rd",     32'(bus.rd),          32'h9);
      chk("fd_rn",     32'(bus.rn),          32'h3);
      chk("fd_rs",     32'(bus.rs),          32'hA);
      chk("fd_rm",     32'(bus.rm),          32'h5);
      chk("fd_imm12",  32'(bus.imm12),       32'hA35);
      chk("fd_br_off", bus.br_off,           32'h00C9_8A35);

      // backpressure: ten cycles held in HOLD
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid",  32'(bus.instr_valid), 32'd1);
         chk("bp_rd_en",  32'(bus.ram_rd_en),   32'd0);
         chk("bp_pc_out", 32'(bus.pc_out),      32'h100);
         chk("bp_opcode", 32'(bus.opcode),      32'h36);
         chk("bp_imm12",  32'(bus.imm12),       32'hA35);
      end
      bus.waiting = 1'b1;
      tick();
      bus.waiting = 1'b0;
      chk("bp_rel_valid", 32'(bus.instr_valid), 32'd0);
      chk("bp_rel_rd_en", 32'(bus.ram_rd_en),   32'd1);
      chk("bp_rel_addr",  32'(bus.ram_rd_addr), 32'h101);

      // redirect in WAIT: word 0x101 in flight is discarded
      tick();
      bus.load_pc = 1'b1;
      bus.pc_in   = 11'h100;
      tick();
      bus.load_pc = 1'b0;
      chk("rw_valid", 32'(bus.instr_valid), 32'd0);
      chk("rw_addr",  32'(bus.ram_rd_addr), 32'h100);
      tick();
      tick();
      chk("rw_pc_out", 32'(bus.pc_out), 32'h100);
      chk("rw_opcode", 32'(bus.opcode), 32'h36);

      // clear_pc and load_pc together in HOLD: clear wins
      bus.clear_pc = 1'b1;
      bus.load_pc  = 1'b1;
      bus.pc_in    = 11'h7FF;
      tick();
      bus.clear_pc = 1'b0;
      bus.load_pc  = 1'b0;
      chk("rc_valid", 32'(bus.instr_valid), 32'd0);
      chk("rc_addr",  32'(bus.ram_rd_addr), 32'd0);
      tick();
      tick();
      chk("rc_pc_out", 32'(bus.pc_out), 32'd0);
      chk("rc_opcode", 32'(bus.opcode), 32'h11);

      // accept with redirect in the same cycle: target replaces PC+1
      bus.waiting = 1'b1;
      bus.load_pc = 1'b1;
      bus.pc_in   = 11'h7FF;
      tick();
      bus.load_pc = 1'b0;
      chk("ar_addr",  32'(bus.ram_rd_addr), 32'h7FF);
      chk("ar_valid", 32'(bus.instr_valid), 32'd0);
      tick();
      tick();
      chk("ar_pc_out", 32'(bus.pc_out), 32'h7FF);
      chk("ar_opcode", 32'(bus.opcode), 32'h12);
      tick();
      chk("wrap_addr",  32'(bus.ram_rd_addr), 32'd0);
      chk("wrap_rd_en", 32'(bus.ram_rd_en),   32'd1);

      // run 0,1,2 then HLT at 3
      repeat (11) tick();
      chk("hlt_valid",  32'(bus.instr_valid), 32'd1);
      chk("hlt_opcode", 32'(bus.opcode),      32'h01);
      chk("hlt_pc_out", 32'(bus.pc_out),      32'd3);
      bus.load_pc = 1'b1;
      bus.pc_in   = 11'd3;
      tick();
      bus.load_pc = 1'b0;
      chk("hsup_halted", 32'(bus.halted),      32'd0);
      chk("hsup_addr",   32'(bus.ram_rd_addr), 32'd3);
      tick();
      tick();
      chk("hlt2_opcode", 32'(bus.opcode), 32'h01);
      tick();
      chk("halt_halted", 32'(bus.halted),      32'd1);
      chk("halt_valid",  32'(bus.instr_valid), 32'd0);
      chk("halt_rd_en",  32'(bus.ram_rd_en),   32'd0);
      bus.load_pc = 1'b1;
      bus.pc_in   = 11'h100;
      tick();
      bus.load_pc = 1'b0;
      chk("hred_halted", 32'(bus.halted),    32'd1);
      chk("hred_rd_en",  32'(bus.ram_rd_en), 32'd0);
      repeat (3) tick();
      chk("hstay_halted", 32'(bus.halted),    32'd1);
      chk("hstay_rd_en",  32'(bus.ram_rd_en), 32'd0);

      rst_n = 1'b0;
      #1;
      chk("hrst_halted", 32'(bus.halted),      32'd0);
      chk("hrst_pc_out", 32'(bus.pc_out),      32'd0);
      chk("hrst_opcode", 32'(bus.opcode),      32'd0);
      chk("hrst_rd_en",  32'(bus.ram_rd_en),   32'd0);

      // reset asserted during WAIT with a non-zero IR
      tick();
      rst_n = 1'b1;
      #1;
      chk("m0_addr", 32'(bus.ram_rd_addr), 32'd0);
      tick();
      tick();
      chk("m2_opcode", 32'(bus.opcode), 32'h11);
      tick();
      tick();
      chk("m4_opcode", 32'(bus.opcode),    32'h11);
      chk("m4_rd_en",  32'(bus.ram_rd_en), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mrst_rd_en",  32'(bus.ram_rd_en),   32'd0);
      chk("mrst_valid",  32'(bus.instr_valid), 32'd0);
      chk("mrst_opcode", 32'(bus.opcode),      32'd0);
      chk("mrst_br_off", bus.br_off,           32'd0);
      chk("mrst_halted", 32'(bus.halted),      32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("mrel_rd_en", 32'(bus.ram_rd_en),   32'd1);
      chk("mrel_addr",  32'(bus.ram_rd_addr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
